stage_block_feeder: RTL and testbench



---
 rtl/stage_pkg.sv | 34 +++
 rtl/blk_fifo.sv | 80 ++++++++
 rtl/stage_block_feeder.sv | 146 ++++++++++++++
 tb/tb_stage_block_feeder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_pkg.sv
// Shared record type, FSM states and ROM geometry for the stage-block feeder.
// ROM records are {left, right, height, stat}; stat fills the low bits left over after three position fields.
package stage_pkg;

  localparam int STG_POS_W  = 16;
  localparam int STG_BLK_W  = 52;
  localparam int STG_STAT_W = STG_BLK_W - 3 * STG_POS_W;
  localparam int STG_NREC   = 8;
  localparam int STG_ADDRW  = $clog2(STG_NREC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [STG_POS_W-1:0] left;
    logic [STG_POS_W-1:0] right;
    logic [STG_POS_W-1:0] height;
    logic [STG_POS_W-1:0] stat;
  } blk_t;

  // stat is narrower in the ROM than on the output bus and is zero-extended
  function automatic blk_t unpack_blk(input logic [STG_BLK_W-1:0] data);
    blk_t b;
    b.left   = data[STG_BLK_W-1 -: STG_POS_W];
    b.right  = data[STG_BLK_W-STG_POS_W-1 -: STG_POS_W];
    b.height = data[STG_STAT_W +: STG_POS_W];
    b.stat   = STG_POS_W'(data[STG_STAT_W-1:0]);
    return b;
  endfunction

endpackage

// File: rtl/blk_fifo.sv
// Synchronous FIFO of stage records with a registered head and a synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module blk_fifo
  import stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  blk_t                   din_i,
  output blk_t                   head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  blk_t          mem_q [DEPTH];
  blk_t          head_q, head_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nx;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rd_nx = rd_q + 1'b1;

  // The head register always mirrors mem[rd]; on a pop it preloads the entry behind it.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (clear_i) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      head_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_nx;
      case ({push_i, pop_i})
        2'b10: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) head_d = din_i;
        end
        2'b01: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q > CW'(1)) head_d = mem_q[rd_nx];
        end
        2'b11:   head_d = (cnt_q == CW'(1)) ? din_i : mem_q[rd_nx];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = head_q;
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/stage_block_feeder.sv
// Streams stage-block records from a 1-cycle-latency ROM into a FIFO for the stage buffer.
// Define STG_LAP_OFFSET_EN to add a per-lap offset to left/right on every ROM wrap.
module stage_block_feeder
  import stage_pkg::*;
#(
  parameter int                   BLK_BITS   = STG_BLK_W,
  parameter int                   POS_DIGIT  = STG_POS_W,
  parameter int                   STG_DEPTH  = 1 << STG_ADDRW,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [POS_DIGIT-1:0] LAP_LEN    = 16'd4000
) (
  input  logic                         i_clk_pix,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_flush,
  output logic [$clog2(STG_DEPTH)-1:0] o_rom_addr,
  input  logic [BLK_BITS-1:0]          i_rom_data,
  output logic                         o_blk_valid,
  input  logic                         i_blk_ready,
  output logic [POS_DIGIT-1:0]         o_blk_left,
  output logic [POS_DIGIT-1:0]         o_blk_right,
  output logic [POS_DIGIT-1:0]         o_blk_height,
  output logic [POS_DIGIT-1:0]         o_blk_stat,
  output logic [7:0]                   o_lap,
  output logic                         o_err
);

  localparam int AW = $clog2(STG_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 inflight_q, inflight_d;
  logic [7:0]           lap_q, lap_d;
  logic                 err_q, err_d;
  logic [POS_DIGIT-1:0] rec_off;
  logic                 flush, issue, wrap, capture, keep, drop, pop, fifo_valid;
  logic [CW-1:0]        fifo_cnt;
  blk_t                 rec, head;

  assign flush   = i_flush && (state_q != S_IDLE);
  assign issue   = (state_q == S_FETCH) && !i_flush &&
                   (int'(fifo_cnt) + int'(inflight_q) < FIFO_DEPTH);
  assign wrap    = issue && (addr_q == AW'(STG_DEPTH - 1));
  assign capture = inflight_q && !flush;
  assign keep    = capture && (rec.left <= rec.right);
  assign drop    = capture && (rec.left > rec.right);
  assign pop     = fifo_valid && i_blk_ready && !flush;

`ifdef STG_LAP_OFFSET_EN
  // off_fl_q freezes the offset seen at issue so the last record of a lap keeps the old one.
  logic [POS_DIGIT-1:0] off_q, off_d, off_fl_q, off_fl_d;

  always_comb begin
    off_d    = off_q;
    off_fl_d = off_fl_q;
    if (flush) begin
      off_d    = '0;
      off_fl_d = '0;
    end else if (issue) begin
      off_fl_d = off_q;
      if (wrap) off_d = off_q + LAP_LEN;
    end
  end

  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      off_q    <= '0;
      off_fl_q <= '0;
    end else begin
      off_q    <= off_d;
      off_fl_q <= off_fl_d;
    end
  end

  assign rec_off = off_fl_q;
`else
  assign rec_off = LAP_LEN & '0;
`endif

  always_comb begin
    rec       = unpack_blk(i_rom_data);
    rec.left  = rec.left + rec_off;
    rec.right = rec.right + rec_off;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    inflight_d = issue;
    lap_d      = lap_q;
    err_d      = err_q || drop;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_FETCH;
      S_FETCH: if (flush) state_d = S_FLUSH;
      S_FLUSH: state_d = flush ? S_FLUSH : S_FETCH;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      addr_d     = '0;
      inflight_d = 1'b0;
      lap_d      = '0;
    end else if (issue) begin
      addr_d = wrap ? '0 : addr_q + 1'b1;
      if (wrap && lap_q != 8'hFF) lap_d = lap_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      lap_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      lap_q      <= lap_d;
      err_q      <= err_d;
    end
  end

  blk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_clk_pix),
    .rst_ni  (i_rst_n),
    .clear_i (flush),
    .push_i  (keep),
    .pop_i   (pop),
    .din_i   (rec),
    .head_o  (head),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign o_rom_addr   = addr_q;
  assign o_blk_valid  = fifo_valid;
  assign o_blk_left   = head.left;
  assign o_blk_right  = head.right;
  assign o_blk_height = head.height;
  assign o_blk_stat   = head.stat;
  assign o_lap        = lap_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_stage_block_feeder.sv
// Bench for stage_block_feeder: ROM model plus a record-sequence reference model.
module tb_stage_block_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic [2:0]  addr;
  logic [51:0] rom_data;
  logic        vld;
  logic [15:0] left, right, height, stat;
  logic [7:0]  lap;
  logic        err;
  logic [51:0] rom [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[addr];

  stage_block_feeder dut (
    .i_clk_pix    (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_flush      (flush),
    .o_rom_addr   (addr),
    .i_rom_data   (rom_data),
    .o_blk_valid  (vld),
    .i_blk_ready  (ready),
    .o_blk_left   (left),
    .o_blk_right  (right),
    .o_blk_height (height),
    .o_blk_stat   (stat),
    .o_lap        (lap),
    .o_err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [51:0] mk(input logic [15:0] l, input logic [15:0] r,
                                     input logic [15:0] h, input logic [3:0] s);
    return {l, r, h, s};
  endfunction

  // Record n of the endless stream: ROM address n%8 on lap n/8.
  function automatic logic [63:0] m_rec(input int n);
    logic [51:0] r;
    logic [15:0] off;
    r = rom[n % 8];
`ifdef STG_LAP_OFFSET_EN
    off = 16'((n / 8) * 4000);
`else
    off = 16'd0;
`endif
    return {r[51:36] + off, r[35:20] + off, r[19:4], 12'd0, r[3:0]};
  endfunction

  function automatic bit m_ok(input int n);
    logic [63:0] x;
    x = m_rec(n);
    return x[63:48] <= x[47:32];
  endfunction

  function automatic logic [63:0] head_now();
    return {left, right, height, stat};
  endfunction

  // Consumer always ready from the flush edge: one read per cycle, record n at head k=n+3 cycles after flush.
  task automatic run_timed(input int ncyc, input bit err0);
    bit          err_exp;
    logic [2:0]  ea;
    logic [7:0]  el;
    logic [15:0] l8;
    err_exp = err0;
    for (int k = 0; k < ncyc; k++) begin
      ea = (k <= 1) ? 3'd0 : 3'((k - 1) % 8);
      el = (k <= 1) ? 8'd0 : 8'((k - 1) / 8);
      if (k >= 3 && !m_ok(k - 3)) err_exp = 1'b1;
      checks++;
      if (addr !== ea) begin
        errors++; $display("FAIL timed_addr k=%0d got %0d expected %0d", k, addr, ea);
      end
      checks++;
      if (lap !== el) begin
        errors++; $display("FAIL timed_lap k=%0d got %0d expected %0d", k, lap, el);
      end
      checks++;
      if (err !== err_exp) begin
        errors++; $display("FAIL timed_err k=%0d got %0b expected %0b", k, err, err_exp);
      end
      checks++;
      if (k < 3) begin
        if (vld !== 1'b0) begin
          errors++; $display("FAIL timed_early_valid k=%0d got %0b expected 0", k, vld);
        end
      end else if (vld !== m_ok(k - 3)) begin
        errors++; $display("FAIL timed_valid k=%0d got %0b expected %0b", k, vld, m_ok(k - 3));
      end else if (vld && head_now() !== m_rec(k - 3)) begin
        errors++; $display("FAIL timed_head k=%0d got %h expected %h", k, head_now(), m_rec(k - 3));
      end
      if (k == 11) begin
`ifdef STG_LAP_OFFSET_EN
        l8 = 16'd4010;
`else
        l8 = 16'd10;
`endif
        checks++;
        if (left !== l8 || lap !== 8'd1) begin
          errors++; $display("FAIL lap1_addr0 left got %0d expected %0d lap got %0d expected 1", left, l8, lap);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if (addr !== 3'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", addr); end
    checks++;
    if (vld !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", vld); end
    checks++;
    if (head_now() !== 64'd0) begin errors++; $display("FAIL reset_fields got %h expected 0", head_now()); end
    checks++;
    if (lap !== 8'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_lap_err got %0d/%0b expected 0/0", lap, err);
    end
    flush = 1'b1; tick(); flush = 1'b0; tick(); tick();
    checks++;
    if (addr !== 3'd0 || vld !== 1'b0) begin
      errors++; $display("FAIL idle_flush addr got %0d valid got %0b expected 0/0", addr, vld);
    end
  endtask

  task automatic test_first_record();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (vld !== 1'b0) begin errors++; $display("FAIL first_e0_valid got %0b expected 0", vld); end
    tick();
    checks++;
    if (vld !== 1'b0) begin errors++; $display("FAIL first_e1_valid got %0b expected 0", vld); end
    tick();
    checks++;
    if (vld !== 1'b1 || head_now() !== {16'd10, 16'd50, 16'd100, 16'd0}) begin
      errors++; $display("FAIL first_e2_head valid %0b got %h expected 000a003200640000", vld, head_now());
    end
  endtask

  task automatic test_backpressure();
    repeat (8) tick();
    checks++;
    if (addr !== 3'd4) begin errors++; $display("FAIL bp_reads got addr %0d expected 4", addr); end
    checks++;
    if (vld !== 1'b1 || head_now() !== m_rec(0)) begin
      errors++; $display("FAIL bp_head got %h expected %h", head_now(), m_rec(0));
    end
    ready = 1'b1; tick(); ready = 1'b0;
    checks++;
    if (vld !== 1'b1 || head_now() !== m_rec(1)) begin
      errors++; $display("FAIL bp_pop_head got %h expected %h", head_now(), m_rec(1));
    end
    repeat (6) tick();
    checks++;
    if (addr !== 3'd5) begin errors++; $display("FAIL bp_one_read got addr %0d expected 5", addr); end
  endtask

  task automatic test_flush_pop();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    checks++;
    if (vld !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %0b expected 1", vld); end
    ready = 1'b1; flush = 1'b1; tick(); flush = 1'b0;
    run_timed(20, 1'b0);
  endtask

  task automatic test_bad_record();
    rom[3] = mk(16'd60, 16'd20, 16'd7, 4'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    run_timed(20, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0; tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b expected 1", err); end
  endtask

  task automatic test_random_stream();
    int mn;
    int pops;
    bit r;
    mn = 0; pops = 0;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int c = 0; c < 150; c++) begin
      r = 1'($urandom_range(0, 1));
      if (vld && r) begin
        while (!m_ok(mn) && mn < 10000) mn++;
        checks++;
        if (head_now() !== m_rec(mn)) begin
          errors++; $display("FAIL rand_head n=%0d got %h expected %h", mn, head_now(), m_rec(mn));
        end
        mn++; pops++;
      end
      ready = r;
      tick();
    end
    checks++;
    if (pops < 30) begin errors++; $display("FAIL rand_pops got %0d expected at least 30", pops); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL rand_err got %0b expected 1", err); end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (addr !== 3'd0 || vld !== 1'b0 || head_now() !== 64'd0 || lap !== 8'd0 || err !== 1'b0) begin
      errors++; $display("FAIL async_reset got addr %0d valid %0b head %h lap %0d err %0b expected all 0",
                         addr, vld, head_now(), lap, err);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (addr !== 3'd0 || vld !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle cyc=%0d got addr %0d valid %0b expected 0/0", i, addr, vld);
      end
    end
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    checks++;
    if (vld !== 1'b1 || head_now() !== m_rec(0)) begin
      errors++; $display("FAIL restart_head got %h expected %h", head_now(), m_rec(0));
    end
  endtask

  initial begin
    int l;
    for (int i = 0; i < 8; i++) begin
      l = $urandom_range(0, 30000);
      rom[i] = mk(16'(l), 16'(l + $urandom_range(0, 3000)), 16'($urandom), 4'($urandom));
    end
    rom[0] = mk(16'd10, 16'd50, 16'd100, 4'd0);
    test_reset();
    test_first_record();
    test_backpressure();
    test_flush_pop();
    test_bad_record();
    test_random_stream();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
